macc_lanes: RTL and testbench
=============================

Name: macc_lanes

Overview:
Multi-lane, parametrised successor to the single-channel fixed-point multiply-accumulate primitive. It runs NUM_LANES independent MACC datapaths in lockstep, sharing one op_code, valid and clear. It adds a valid-qualified pipeline, configurable Q-format alignment, and round-to-nearest output scaling. It sits between the PE input buffers and the output writeback in the convolution and fully-connected compute arrays.

Parameters:
NUM_LANES, 4, number of parallel MACC lanes
OP_WIDTH, 16, signed operand and op_add width (Q format, FRAC_BITS fractional bits)
ACC_WIDTH, 48, signed per-lane accumulator width; must be >= 2*OP_WIDTH
OUT_WIDTH, 16, signed per-lane result width
FRAC_BITS, 7, fractional bits of operands and result; 0 is legal

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  lane inputs valid this cycle
clear  in  1  qualified by in_valid; start a new accumulation with this beat
op_code  in  3  bit0 square (op_1 ignored, op_0 used twice); bits[2:1]: 00 multiply, 01 multiply-acc, 10 multiply-add, 11 reserved (treat as 00)
op_0  in  NUM_LANES*OP_WIDTH  flattened signed operand A, lane i at [i*OP_WIDTH +: OP_WIDTH]
op_1  in  NUM_LANES*OP_WIDTH  flattened signed operand B
op_add  in  NUM_LANES*OP_WIDTH  flattened signed addend, same Q format as the operands
out_valid  out  1  out is valid
out  out  NUM_LANES*OUT_WIDTH  flattened signed results
sat  out  NUM_LANES  per-lane saturation flag, qualified by out_valid

Behaviour:
- Three-stage pipeline. in_valid propagates alongside the data, and out_valid follows in_valid after exactly 3 cycles. There is no backpressure, and one beat is accepted per cycle.
- S1 registers op_0, op_1 (or op_0 when op_code[0]=1), op_add, op_code, clear and valid. Data registers load 0 when in_valid=0.
- S2 computes product = op_0*op_1 at full 2*OP_WIDTH precision, sign-extended to ACC_WIDTH.
- S3 updates the accumulator, and only when the S2 valid is 1:
  - multiply: acc <= product
  - multiply-acc: acc <= product + (S2 clear ? 0 : acc)
  - multiply-add: acc <= product + (sext(op_add) <<< FRAC_BITS)
- An invalid beat (bubble) holds acc unchanged, so bubbles inside an accumulation are harmless.
- clear only affects multiply-acc beats and travels with its beat. A clear with in_valid=0 is ignored.
- acc wraps modulo 2^ACC_WIDTH in two's complement. There is no accumulator overflow detection.
- Output scaling is combinational from acc:
  - if FRAC_BITS>0: r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, computed at ACC_WIDTH+1 bits (round half toward +inf)
  - if FRAC_BITS=0: r = acc
  - out lane = narrow(r); narrowing is defined under Optional Feature.
- out and sat remain stable while out_valid=0. They hold the last valid result.
- Reset values: acc of every lane 0, all pipeline data 0, all valids 0, out_valid 0, out 0, sat 0.
- Reset mid-operation: all in-flight beats are dropped, and no out_valid pulse occurs for beats accepted before reset deasserts. The first beat after reset behaves as if clear=1.
- Lanes are fully independent. Only op_code, valid and clear are shared.

Optional Feature:
Macro MACC_LANES_SATURATE_EN.
- Defined: narrow(r) clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], and sat[i]=1 when lane i clamped.
- Undefined: narrow(r) = r[OUT_WIDTH-1:0] (wrap), and sat is tied to 0.
- The accumulator always wraps regardless of the macro.

Test Plan:
All scenarios use the default parameters (1.0 = 128).
- Multiply, lane0 op_0=256, op_1=384, op_code=0 -> 3 cycles later out_valid=1, out lane0=768, sat=0.
- Multiply-acc: 4 consecutive beats, op_0=op_1=128, op_code=2, clear on beat 1 -> final out=512. Insert 2 bubbles between beats -> same final 512. A fresh clear beat of 128*128 -> out=128.
- Multiply-add: op_0=128, op_1=128, op_add=64, op_code=4 -> acc=24576, out=192. Square: op_0=-384, op_1=999, op_code=1 -> out=1152 (op_1 ignored).
- Overflow: op_0=op_1=32767, op_code=0:
  - with macro -> out=32767, sat=1
  - without macro -> out=-512 (0xFE00), sat=0
- Rounding, multiply: op_0=1, op_1=64 -> out=1. op_0=-1, op_1=64 -> out=0.
- Lane independence and reset:
  - distinct values per lane -> each lane matches its own model
  - assert reset 1 cycle after a valid beat -> no out_valid, and out=0 on all lanes

Source files
------------

// File: rtl/macc_lanes.sv
// NUM_LANES parallel fixed-point MACC lanes sharing op_code/valid/clear, 3-stage pipeline.
// Define MACC_LANES_SATURATE_EN to clamp results (with sat flags) instead of wrapping.
module macc_lanes #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned OP_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH = 48,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned FRAC_BITS = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid_i,
  input  logic                           clear_i,
  input  logic [2:0]                     op_code_i,
  input  logic [NUM_LANES*OP_WIDTH-1:0]  op_0_i,
  input  logic [NUM_LANES*OP_WIDTH-1:0]  op_1_i,
  input  logic [NUM_LANES*OP_WIDTH-1:0]  op_add_i,
  output logic                           out_valid_o,
  output logic [NUM_LANES*OUT_WIDTH-1:0] out_o,
  output logic [NUM_LANES-1:0]           sat_o
);

  localparam int unsigned LaneBits  = NUM_LANES * OP_WIDTH;
  localparam int unsigned ProdWidth = 2 * OP_WIDTH;
  localparam int unsigned RndWidth  = ACC_WIDTH + 1;

  localparam logic [1:0] ModeMacc = 2'b01;
  localparam logic [1:0] ModeMadd = 2'b10;

  // Stage 1: operand capture; square mode substitutes op_0 for op_1 here.
  logic                s1_valid_q, s1_clear_q;
  logic [1:0]          s1_mode_q;
  logic [LaneBits-1:0] s1_a_q, s1_b_q, s1_add_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_clear_q <= 1'b0;
      s1_mode_q  <= 2'b00;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_add_q   <= '0;
    end else begin
      s1_valid_q <= in_valid_i;
      s1_clear_q <= in_valid_i & clear_i;
      s1_mode_q  <= in_valid_i ? op_code_i[2:1] : 2'b00;
      s1_a_q     <= in_valid_i ? op_0_i : '0;
      s1_b_q     <= in_valid_i ? (op_code_i[0] ? op_0_i : op_1_i) : '0;
      s1_add_q   <= in_valid_i ? op_add_i : '0;
    end
  end

  // Stage 2: full-precision products, sign-extended to the accumulator width.
  logic                        s2_valid_q, s2_clear_q;
  logic [1:0]                  s2_mode_q;
  logic [LaneBits-1:0]         s2_add_q;
  logic signed [ACC_WIDTH-1:0] s2_prod_q [NUM_LANES];
  logic signed [ACC_WIDTH-1:0] s2_prod_d [NUM_LANES];

  always_comb begin
    logic signed [OP_WIDTH-1:0]  mul_a;
    logic signed [OP_WIDTH-1:0]  mul_b;
    logic signed [ProdWidth-1:0] mul_p;
    mul_a = '0;
    mul_b = '0;
    mul_p = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      mul_a        = s1_a_q[i*OP_WIDTH +: OP_WIDTH];
      mul_b        = s1_b_q[i*OP_WIDTH +: OP_WIDTH];
      mul_p        = mul_a * mul_b;
      s2_prod_d[i] = ACC_WIDTH'(mul_p);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_clear_q <= 1'b0;
      s2_mode_q  <= 2'b00;
      s2_add_q   <= '0;
      for (int i = 0; i < NUM_LANES; i++) s2_prod_q[i] <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_clear_q <= s1_clear_q;
      s2_mode_q  <= s1_mode_q;
      s2_add_q   <= s1_add_q;
      for (int i = 0; i < NUM_LANES; i++) s2_prod_q[i] <= s2_prod_d[i];
    end
  end

  // Stage 3: accumulator update; bubbles leave acc untouched.
  logic signed [ACC_WIDTH-1:0] acc_q [NUM_LANES];
  logic signed [ACC_WIDTH-1:0] acc_d [NUM_LANES];
  logic                        out_valid_q;

  always_comb begin
    logic signed [OP_WIDTH-1:0]  add_op;
    logic signed [ACC_WIDTH-1:0] addend;
    add_op = '0;
    addend = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      add_op   = s2_add_q[i*OP_WIDTH +: OP_WIDTH];
      addend   = ACC_WIDTH'(add_op) <<< FRAC_BITS;
      acc_d[i] = acc_q[i];
      if (s2_valid_q) begin
        case (s2_mode_q)
          ModeMacc: acc_d[i] = s2_prod_q[i] + (s2_clear_q ? '0 : acc_q[i]);
          ModeMadd: acc_d[i] = s2_prod_q[i] + addend;
          default:  acc_d[i] = s2_prod_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) acc_q[i] <= '0;
    end else begin
      out_valid_q <= s2_valid_q;
      for (int i = 0; i < NUM_LANES; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign out_valid_o = out_valid_q;

  // Output scaling is combinational from acc, so out/sat hold between valid beats.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic signed [RndWidth-1:0] acc_ext;
    logic signed [RndWidth-1:0] rnd;

    assign acc_ext = RndWidth'(acc_q[gi]);

    if (FRAC_BITS > 0) begin : g_round
      assign rnd = (acc_ext + (RndWidth'(1) <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
    end else begin : g_no_round
      assign rnd = acc_ext;
    end

`ifdef MACC_LANES_SATURATE_EN
    localparam logic [OUT_WIDTH-1:0] OutMax = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OutMin = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic [RndWidth-OUT_WIDTH:0] rnd_hi;
    logic                        in_range;

    // Representable iff all bits from the output sign bit upward agree.
    assign rnd_hi   = rnd[RndWidth-1:OUT_WIDTH-1];
    assign in_range = (&rnd_hi) | ~(|rnd_hi);
    assign out_o[gi*OUT_WIDTH +: OUT_WIDTH] =
        in_range ? rnd[OUT_WIDTH-1:0] : (rnd[RndWidth-1] ? OutMin : OutMax);
    assign sat_o[gi] = ~in_range;
`else
    logic unused_rnd_hi;

    assign unused_rnd_hi = ^rnd[RndWidth-1:OUT_WIDTH];
    assign out_o[gi*OUT_WIDTH +: OUT_WIDTH] = rnd[OUT_WIDTH-1:0];
    assign sat_o[gi] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_macc_lanes.sv
// Directed bench for macc_lanes: table of single-beat vectors plus multi-cycle sequences.
module tb_macc_lanes;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_i, clear_i;
  logic [2:0]  op_code_i;
  logic [63:0] op_0_i, op_1_i, op_add_i;
  logic        out_valid_o;
  logic [63:0] out_o;
  logic [3:0]  sat_o;

  int total = 0;
  int bad   = 0;

  macc_lanes dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (in_valid_i),
    .clear_i    (clear_i),
    .op_code_i  (op_code_i),
    .op_0_i     (op_0_i),
    .op_1_i     (op_1_i),
    .op_add_i   (op_add_i),
    .out_valid_o(out_valid_o),
    .out_o      (out_o),
    .sat_o      (sat_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  code;
    logic        clr;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] add;
    logic [63:0] exp_out;
    logic [3:0]  exp_sat;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [63:0] p4(int l0, int l1, int l2, int l3);
    return {l3[15:0], l2[15:0], l1[15:0], l0[15:0]};
  endfunction

  task automatic check(string name, logic signed [63:0] got, logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  task automatic check_lanes(string name, logic [63:0] exp_out, logic [3:0] exp_sat);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s.out%0d", name, i), $signed(out_o[i*16 +: 16]),
            $signed(exp_out[i*16 +: 16]));
    end
    check($sformatf("%s.sat", name), {60'd0, sat_o}, {60'd0, exp_sat});
  endtask

  task automatic drive(logic v, logic c, logic [2:0] code, logic [63:0] a, logic [63:0] b,
                       logic [63:0] add);
    @(negedge clk);
    in_valid_i = v;
    clear_i    = c;
    op_code_i  = code;
    op_0_i     = a;
    op_1_i     = b;
    op_add_i   = add;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 64'd0);
  endtask

  // One valid beat, then checks out_valid is low at +2 cycles and high at +3.
  task automatic beat_and_wait(string name, logic c, logic [2:0] code, logic [63:0] a,
                               logic [63:0] b, logic [63:0] add);
    drive(1'b1, c, code, a, b, add);
    idle();
    @(negedge clk);
    check({name, ".ov_early"}, {63'd0, out_valid_o}, 64'd0);
    @(negedge clk);
    check({name, ".ov"}, {63'd0, out_valid_o}, 64'd1);
  endtask

  initial begin
    logic [63:0] one_all;
    int          mexp[3];

    one_all = p4(128, 128, 128, 128);

    // Multiply with rounding: 256*384 -> 768, 1*64 -> 1 (half up), -1*64 -> 0, -384*999 -> -2997
    vecs[0] = '{3'd0, 1'b0, p4(256, 1, -1, -384), p4(384, 64, 64, 999), 64'd0,
                p4(768, 1, 0, -2997), 4'b0000};
    // Multiply-add: op_add scaled into acc
    vecs[1] = '{3'd4, 1'b0, p4(128, 256, 0, -128), p4(128, 128, 0, 128),
                p4(64, -128, 5, 0), p4(192, 128, 5, -128), 4'b0000};
    // Square: op_1 ignored
    vecs[2] = '{3'd1, 1'b0, p4(-384, 128, 0, -128), p4(999, 0, 77, 5), 64'd0,
                p4(1152, 128, 0, 128), 4'b0000};
    // Overflow of the 16-bit result
`ifdef MACC_LANES_SATURATE_EN
    vecs[3] = '{3'd0, 1'b0, p4(32767, -32768, -32768, 2), p4(32767, -32768, 32767, 3), 64'd0,
                p4(32767, 32767, -32768, 0), 4'b0111};
`else
    vecs[3] = '{3'd0, 1'b0, p4(32767, -32768, -32768, 2), p4(32767, -32768, 32767, 3), 64'd0,
                p4(-512, 0, 256, 0), 4'b0000};
`endif
    // Reserved op_code 11 behaves as multiply
    vecs[4] = '{3'd6, 1'b0, p4(100, 3, -3, 64), p4(200, -3, -3, 1), p4(9, 9, 9, 9),
                p4(156, 0, 0, 1), 4'b0000};
    // Multiply-acc with clear on a single beat
    vecs[5] = '{3'd2, 1'b1, p4(128, -128, 300, 7), p4(128, 128, -2, 9), 64'd0,
                p4(128, -128, -5, 0), 4'b0000};

    reset      = 1'b1;
    in_valid_i = 1'b0;
    clear_i    = 1'b0;
    op_code_i  = 3'd0;
    op_0_i     = '0;
    op_1_i     = '0;
    op_add_i   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset.ov", {63'd0, out_valid_o}, 64'd0);
    check("reset.out", out_o, 64'd0);
    check("reset.sat", {60'd0, sat_o}, 64'd0);

    for (int v = 0; v < 6; v++) begin
      beat_and_wait($sformatf("vec%0d", v), vecs[v].clr, vecs[v].code, vecs[v].a, vecs[v].b,
                    vecs[v].add);
      check_lanes($sformatf("vec%0d", v), vecs[v].exp_out, vecs[v].exp_sat);
    end

    // Four back-to-back accumulate beats: running sum 128, 256, 384, 512
    for (int k = 0; k < 4; k++) drive(1'b1, k == 0, 3'd2, one_all, one_all, 64'd0);
    check("b2b.ov0", {63'd0, out_valid_o}, 64'd1);
    check("b2b.out0", $signed(out_o[15:0]), 64'sd128);
    mexp = '{256, 384, 512};
    for (int k = 0; k < 3; k++) begin
      if (k == 0) idle();
      else @(negedge clk);
      check($sformatf("b2b.ov%0d", k + 1), {63'd0, out_valid_o}, 64'd1);
      check($sformatf("b2b.out%0d", k + 1), $signed(out_o[15:0]), 64'(mexp[k]));
    end

    // Same accumulation with two bubbles between beats
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, k == 0, 3'd2, one_all, one_all, 64'd0);
      idle();
      idle();
    end
    check("bub.hold_ov", {63'd0, out_valid_o}, 64'd0);
    check("bub.hold_out", $signed(out_o[15:0]), 64'sd384);
    @(negedge clk);
    check("bub.ov", {63'd0, out_valid_o}, 64'd1);
    check_lanes("bub", p4(512, 512, 512, 512), 4'b0000);

    beat_and_wait("fresh", 1'b1, 3'd2, one_all, one_all, 64'd0);
    check_lanes("fresh", one_all, 4'b0000);

    // A clear without in_valid must not reset the running sum
    drive(1'b0, 1'b1, 3'd2, one_all, one_all, 64'd0);
    beat_and_wait("ignclr", 1'b0, 3'd2, one_all, one_all, 64'd0);
    check_lanes("ignclr", p4(256, 256, 256, 256), 4'b0000);

    // Reset one cycle after a valid beat: the beat is dropped and acc returns to 0
    drive(1'b1, 1'b0, 3'd0, p4(256, 512, 1000, -700), p4(384, 3, 7, 11), 64'd0);
    @(negedge clk);
    reset      = 1'b1;
    in_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst.ov%0d", k), {63'd0, out_valid_o}, 64'd0);
      @(negedge clk);
    end
    check("rst.out", out_o, 64'd0);
    check("rst.sat", {60'd0, sat_o}, 64'd0);

    // First accumulate beat after reset starts from zero even without clear
    beat_and_wait("postrst", 1'b0, 3'd2, p4(128, 256, -128, 64), one_all, 64'd0);
    check_lanes("postrst", p4(128, 256, -128, 64), 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
